// File: rtl/decode3_8_hold.sv
// Sequential 3-to-8 decoder: accepts {code, valid-flag} over a valid/ready handshake,
// holds a registered one-hot output for HOLD_CYCLES cycles, then blanks for one cycle.
module decode3_8_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             in_y,
  output logic [7:0]       out_onehot,
  output logic             out_active,
  output logic             busy,
  output logic [CNT_W-1:0] zero_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LOAD = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [7:0]       onehot_q, onehot_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic             accept;

  assign in_ready = en & (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    onehot_d   = onehot_q;
    active_d   = active_q;
    zero_cnt_d = zero_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_y) begin
            onehot_d = 8'b1 << in_code;
            active_d = 1'b1;
            timer_d  = TIMER_LOAD;
            state_d  = HOLD;
          end else if (zero_cnt_q != {CNT_W{1'b1}}) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1'b1);
          end
        end
      end
      HOLD: begin
        // Abort on en=0 wins over timer expiry and skips the blank gap.
        if (!en) begin
          onehot_d = 8'h00;
          active_d = 1'b0;
          timer_d  = 8'h00;
          state_d  = IDLE;
        end else if (timer_q == 8'h00) begin
          onehot_d = 8'h00;
          active_d = 1'b0;
          state_d  = GAP;
        end else begin
          timer_d = timer_q - 8'h01;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        onehot_d = 8'h00;
        active_d = 1'b0;
        timer_d  = 8'h00;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= 8'h00;
      onehot_q   <= 8'h00;
      active_q   <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      onehot_q   <= onehot_d;
      active_q   <= active_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_active = active_q;
  assign busy       = (state_q != IDLE);
  assign zero_cnt   = zero_cnt_q;

endmodule

// File: tb/tb_decode3_8_hold.sv
// Directed, table-driven bench for decode3_8_hold (HOLD_CYCLES=4 main instance,
// plus a HOLD_CYCLES=1 instance for the single-cycle hold case).
module tb_decode3_8_hold;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_y = 1'b0;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_active;
  logic       busy;
  logic [7:0] zero_cnt;

  logic       en1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic [2:0] in_code1 = 3'd0;
  logic       in_y1 = 1'b0;
  logic       in_ready1;
  logic [7:0] out_onehot1;
  logic       out_active1;
  logic       busy1;
  logic [7:0] zero_cnt1;

  int tests = 0;
  int fails = 0;
  int exp_zc = 0;

  always #5 clk = ~clk;

  decode3_8_hold #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_y(in_y), .out_onehot(out_onehot), .out_active(out_active),
    .busy(busy), .zero_cnt(zero_cnt)
  );

  decode3_8_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_code(in_code1), .in_y(in_y1), .out_onehot(out_onehot1), .out_active(out_active1),
    .busy(busy1), .zero_cnt(zero_cnt1)
  );

  typedef struct {
    logic [2:0] code;
    logic       y;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output invariants on the main instance, sampled away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("active_eq_or", {31'd0, out_active}, {31'd0, |out_onehot});
      chk("onehot_max1", {31'd0, ($countones(out_onehot) <= 1)}, 32'd1);
    end
  end

  task automatic offer(input logic [2:0] c, input logic y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_code  = c;
    in_y     = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Caller is positioned #1 after the accept edge.
  task automatic hold_seq(input logic [7:0] exp);
    chk("hold_onehot", {24'd0, out_onehot}, {24'd0, exp});
    chk("hold_active", {31'd0, out_active}, 32'd1);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_ready", {31'd0, in_ready}, 32'd0);
    repeat (H - 1) begin
      @(posedge clk); #1;
      chk("hold_onehot_n", {24'd0, out_onehot}, {24'd0, exp});
    end
    @(posedge clk); #1;
    chk("gap_onehot", {24'd0, out_onehot}, 32'd0);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    chk("gap_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{3'd0, 1'b1, 8'h01};
    vecs[1] = '{3'd1, 1'b1, 8'h02};
    vecs[2] = '{3'd3, 1'b0, 8'h00};
    vecs[3] = '{3'd2, 1'b1, 8'h04};
    vecs[4] = '{3'd3, 1'b1, 8'h08};
    vecs[5] = '{3'd4, 1'b1, 8'h10};
    vecs[6] = '{3'd7, 1'b0, 8'h00};
    vecs[7] = '{3'd5, 1'b1, 8'h20};
    vecs[8] = '{3'd6, 1'b1, 8'h40};
    vecs[9] = '{3'd7, 1'b1, 8'h80};

    // Reset state
    #12;
    chk("rst_onehot", {24'd0, out_onehot}, 32'd0);
    chk("rst_active", {31'd0, out_active}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_zero_cnt", {24'd0, zero_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    en1   = 1'b1;

    // First code 5, full hold/gap timing
    offer(3'd5, 1'b1);
    hold_seq(8'h20);

    // Table sweep with interleaved no-bit-set codes
    for (int i = 0; i < 10; i++) begin
      offer(vecs[i].code, vecs[i].y);
      if (vecs[i].y) begin
        hold_seq(vecs[i].exp);
      end else begin
        exp_zc++;
        chk("zero_onehot", {24'd0, out_onehot}, 32'd0);
        chk("zero_cnt_inc", {24'd0, zero_cnt}, exp_zc);
        chk("zero_ready", {31'd0, in_ready}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
      end
    end

    // HOLD_CYCLES=1 instance: codes 1 then 6 offered continuously
    @(negedge clk);
    in_valid1 = 1'b1; in_y1 = 1'b1; in_code1 = 3'd1;
    @(posedge clk); #1;
    chk("h1_first", {24'd0, out_onehot1}, 32'h02);
    in_code1 = 3'd6;
    @(posedge clk); #1;
    chk("h1_gap_onehot", {24'd0, out_onehot1}, 32'h00);
    chk("h1_gap_ready", {31'd0, in_ready1}, 32'd0);
    @(posedge clk); #1;
    chk("h1_idle_onehot", {24'd0, out_onehot1}, 32'h00);
    chk("h1_idle_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    chk("h1_second", {24'd0, out_onehot1}, 32'h40);
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("h1_second_end", {24'd0, out_onehot1}, 32'h00);

    // Abort: drop en during the 2nd hold cycle
    offer(3'd2, 1'b1);
    chk("abort_c1", {24'd0, out_onehot}, 32'h04);
    @(posedge clk); #1;
    chk("abort_c2", {24'd0, out_onehot}, 32'h04);
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_onehot", {24'd0, out_onehot}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_ready2", {31'd0, in_ready}, 32'd0);

    // en=0 in IDLE: nothing accepted, counter frozen
    in_valid = 1'b1; in_y = 1'b0; in_code = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    in_y = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("dis_zero_cnt", {24'd0, zero_cnt}, exp_zc);
    chk("dis_onehot", {24'd0, out_onehot}, 32'd0);
    chk("dis_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    en = 1'b1;
    #1;
    chk("en_back_ready", {31'd0, in_ready}, 32'd1);

    // en toggled during GAP: GAP still completes into IDLE
    offer(3'd4, 1'b1);
    repeat (H) @(posedge clk);
    #1;
    chk("gtog_gap_busy", {31'd0, busy}, 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("gtog_idle_busy", {31'd0, busy}, 32'd0);
    chk("gtog_onehot", {24'd0, out_onehot}, 32'd0);
    en = 1'b1;

    // Back-to-back zero codes, saturation
    @(negedge clk);
    in_valid = 1'b1; in_y = 1'b0; in_code = 3'd0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (exp_zc < 255) exp_zc++;
      chk("sat_ready", {31'd0, in_ready}, 32'd1);
      chk("sat_zero_cnt", {24'd0, zero_cnt}, exp_zc);
    end
    chk("sat_final", {24'd0, zero_cnt}, 32'd255);
    in_valid = 1'b0;

    // Async reset mid-hold
    offer(3'd7, 1'b1);
    @(posedge clk); #1;
    chk("prerst_onehot", {24'd0, out_onehot}, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_onehot", {24'd0, out_onehot}, 32'd0);
    chk("arst_active", {31'd0, out_active}, 32'd0);
    chk("arst_zero_cnt", {24'd0, zero_cnt}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_zc = 0;
    offer(3'd3, 1'b1);
    hold_seq(8'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
